// File: rtl/symdet_stream_if.sv
// Handshake bundle for symdet_stream: word-in stream (valid/ready/data/mode)
// and result-out stream (valid/ready plus the three results and the mode echo).
interface symdet_stream_if #(
    parameter int WIDTH = 8
);
    localparam int NPAIR = WIDTH / 2;
    localparam int CNT_W = $clog2(NPAIR + 1);
    localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_sym;
    logic [CNT_W-1:0] out_mismatch;
    logic [IDX_W-1:0] out_first;
    logic             out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_sym, out_mismatch, out_first, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_sym, out_mismatch, out_first, out_mode
    );
endinterface

// File: rtl/symdet_stream.sv
// Streaming bit-pair symmetry detector: scans pairs (i, WIDTH-1-i), PAIRS_PER_CYCLE per clock.
// Optional statistics counters are enabled by defining SYMDET_STATS_EN.
module symdet_stream #(
    parameter int WIDTH           = 8,
    parameter int PAIRS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    symdet_stream_if.slave       bus,
    input  logic                 stat_clr,
    output logic [15:0]          stat_words,
    output logic [15:0]          stat_sym
);
    localparam int NPAIR  = WIDTH / 2;
    localparam int NPASS  = NPAIR / PAIRS_PER_CYCLE;
    localparam int CNT_W  = $clog2(NPAIR + 1);
    localparam int IDX_W  = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int PASS_W = $clog2(NPASS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic               found_q, found_d;
    logic               out_sym_q, out_sym_d;
    logic [CNT_W-1:0]   out_mismatch_q, out_mismatch_d;
    logic [IDX_W-1:0]   out_first_q, out_first_d;
    logic               out_mode_q, out_mode_d;

    logic [NPAIR-1:0]                           pair_fail;
    logic [PAIRS_PER_CYCLE-1:0][NPASS-1:0]      col;
    logic [PAIRS_PER_CYCLE-1:0]                 window;
    logic [CNT_W-1:0]                           psum [PAIRS_PER_CYCLE+1];
    logic [IDX_W-1:0]                           cand [PAIRS_PER_CYCLE+1];
    logic [IDX_W-1:0]                           pass_base;

    genvar gi, gj;

    // Mode 1 inverts the failure sense, so a complement-symmetric word scores zero.
    generate
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            assign pair_fail[gi] = data_q[gi] ^ data_q[WIDTH-1-gi] ^ mode_q;
        end
    endgenerate

    // One-hot pass select builds the window of pairs examined this cycle.
    generate
        for (gj = 0; gj < PAIRS_PER_CYCLE; gj++) begin : g_win
            for (gi = 0; gi < NPASS; gi++) begin : g_pass
                assign col[gj][gi] = (pass_q == PASS_W'(gi)) & pair_fail[gi*PAIRS_PER_CYCLE + gj];
            end
            assign window[gj] = |col[gj];
        end
    endgenerate

    assign pass_base = IDX_W'(pass_q) * IDX_W'(PAIRS_PER_CYCLE);
    assign psum[0]   = '0;
    assign cand[PAIRS_PER_CYCLE] = '0;

    // Popcount by prefix sums; lowest failing index by a high-to-low priority chain.
    generate
        for (gj = 0; gj < PAIRS_PER_CYCLE; gj++) begin : g_cnt
            assign psum[gj+1] = psum[gj] + CNT_W'(window[gj]);
            assign cand[gj]   = window[gj] ? (pass_base + IDX_W'(gj)) : cand[gj+1];
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        data_d         = data_q;
        mode_d         = mode_q;
        acc_d          = acc_q;
        first_d        = first_q;
        found_d        = found_q;
        out_sym_d      = out_sym_q;
        out_mismatch_d = out_mismatch_q;
        out_first_d    = out_first_q;
        out_mode_d     = out_mode_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    mode_d  = bus.in_mode;
                    acc_d   = '0;
                    first_d = '0;
                    found_d = 1'b0;
                    pass_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // The cycle after the last pass commits the accumulator to the result registers.
                if (pass_q == PASS_W'(NPASS)) begin
                    out_mismatch_d = acc_q;
                    out_sym_d      = (acc_q == '0);
                    out_first_d    = first_q;
                    out_mode_d     = mode_q;
                    state_d        = DONE;
                end else begin
                    acc_d  = acc_q + psum[PAIRS_PER_CYCLE];
                    pass_d = pass_q + PASS_W'(1);
                    if (|window && !found_q) begin
                        first_d = cand[0];
                        found_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pass_q         <= '0;
            data_q         <= '0;
            mode_q         <= 1'b0;
            acc_q          <= '0;
            first_q        <= '0;
            found_q        <= 1'b0;
            out_sym_q      <= 1'b0;
            out_mismatch_q <= '0;
            out_first_q    <= '0;
            out_mode_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            data_q         <= data_d;
            mode_q         <= mode_d;
            acc_q          <= acc_d;
            first_q        <= first_d;
            found_q        <= found_d;
            out_sym_q      <= out_sym_d;
            out_mismatch_q <= out_mismatch_d;
            out_first_q    <= out_first_d;
            out_mode_q     <= out_mode_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_sym      = out_sym_q;
    assign bus.out_mismatch = out_mismatch_q;
    assign bus.out_first    = out_first_q;
    assign bus.out_mode     = out_mode_q;

`ifdef SYMDET_STATS_EN
    logic        done_fire;
    logic [15:0] stat_words_q, stat_words_d;
    logic [15:0] stat_sym_q, stat_sym_d;

    assign done_fire = (state_q == DONE) && bus.out_ready;

    // Clear wins over a same-cycle completion; both counters stick at all-ones.
    always_comb begin
        stat_words_d = stat_words_q;
        stat_sym_d   = stat_sym_q;
        if (stat_clr) begin
            stat_words_d = '0;
            stat_sym_d   = '0;
        end else if (done_fire) begin
            if (stat_words_q != 16'hFFFF) begin
                stat_words_d = stat_words_q + 16'd1;
            end
            if (out_sym_q && (stat_sym_q != 16'hFFFF)) begin
                stat_sym_d = stat_sym_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words_q <= '0;
            stat_sym_q   <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_sym_q   <= stat_sym_d;
        end
    end

    assign stat_words = stat_words_q;
    assign stat_sym   = stat_sym_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_words      = '0;
    assign stat_sym        = '0;
`endif
endmodule

// File: tb/tb_symdet_stream.sv
// Randomised self-checking bench for symdet_stream: an 8-bit/1-pair instance and a
// 16-bit/2-pair instance, both scored against a bit-reversal reference model.
module tb_symdet_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_words8, stat_sym8, stat_words16, stat_sym16;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_words8 = 0, exp_sym8 = 0, exp_words16 = 0, exp_sym16 = 0;

    symdet_stream_if #(.WIDTH(8))  bus8 ();
    symdet_stream_if #(.WIDTH(16)) bus16 ();

    symdet_stream #(.WIDTH(8), .PAIRS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave),
        .stat_clr(stat_clr), .stat_words(stat_words8), .stat_sym(stat_sym8)
    );

    symdet_stream #(.WIDTH(16), .PAIRS_PER_CYCLE(2)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave),
        .stat_clr(stat_clr), .stat_words(stat_words16), .stat_sym(stat_sym16)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: compare the word with its own bit-reversal; the low half holds one bit per pair.
    function automatic void ref_model(input logic [15:0] data, input logic mode, input int w,
                                      output int mism, output int first);
        logic [15:0] rev;
        logic [15:0] fails;
        rev = '0;
        for (int i = 0; i < w; i++) rev[i] = data[w-1-i];
        fails = data ^ rev;
        if (mode) fails = ~fails;
        mism  = 0;
        first = -1;
        for (int i = 0; i < w/2; i++) begin
            if (fails[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
    endfunction

    task automatic drive_in(input int w, input logic v, input logic [15:0] d, input logic m);
        if (w == 8) begin
            bus8.in_valid = v; bus8.in_data = d[7:0]; bus8.in_mode = m;
        end else begin
            bus16.in_valid = v; bus16.in_data = d; bus16.in_mode = m;
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 8) bus8.out_ready = r;
        else        bus16.out_ready = r;
    endtask

    // Packed view: [0] out_valid [1] in_ready [2] out_sym [3] out_mode [7:4] first [12:8] mismatch
    function automatic logic [15:0] snap(input int w);
        logic [15:0] s;
        s = '0;
        if (w == 8) begin
            s[0] = bus8.out_valid; s[1] = bus8.in_ready; s[2] = bus8.out_sym; s[3] = bus8.out_mode;
            s[7:4] = {2'b00, bus8.out_first}; s[12:8] = {2'b00, bus8.out_mismatch};
        end else begin
            s[0] = bus16.out_valid; s[1] = bus16.in_ready; s[2] = bus16.out_sym; s[3] = bus16.out_mode;
            s[7:4] = {1'b0, bus16.out_first}; s[12:8] = {1'b0, bus16.out_mismatch};
        end
        return s;
    endfunction

    // Called at #1 after a clock edge with the target block idle.
    task automatic send(input int w, input logic [15:0] data, input logic mode, input int hold);
        int          mism, first, c;
        logic        bad;
        logic [15:0] s, s0;
        ref_model(data, mode, w, mism, first);
        drive_in(w, 1'b1, data, mode);
        set_ready(w, (hold == 0));
        @(posedge clk); #1;
        drive_in(w, 1'($urandom), 16'($urandom), 1'($urandom));
        c   = 0;
        bad = 1'b0;
        while (c <= 40) begin
            s = snap(w);
            if (s[0]) break;
            if (s[1]) bad = 1'b1;
            drive_in(w, 1'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            c++;
        end
        $display("word w=%0d data=%h mode=%0d -> sym=%0d mism=%0d first=%0d lat=%0d (model mism=%0d first=%0d)",
                 w, data, mode, s[2], s[12:8], s[7:4], c, mism, first);
        check_eq("latency", c, 5);
        check_eq("in_ready_low_busy", {31'd0, bad}, 0);
        check_eq("mismatch", {19'd0, s[12:8]}, mism);
        check_eq("first", {28'd0, s[7:4]}, first);
        check_eq("sym", {31'd0, s[2]}, (mism == 0));
        check_eq("mode_echo", {31'd0, s[3]}, {31'd0, mode});
        s0  = s;
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            drive_in(w, 1'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (snap(w) !== s0) bad = 1'b1;
        end
        if (hold > 0) check_eq("hold_stable", {31'd0, bad}, 0);
        drive_in(w, 1'b0, 16'($urandom), 1'($urandom));
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        s = snap(w);
        check_eq("ready_after_take", {30'd0, s[1:0]}, 32'd2);
        if (w == 8) begin
            exp_words8++;  if (mism == 0) exp_sym8++;
        end else begin
            exp_words16++; if (mism == 0) exp_sym16++;
        end
    endtask

    function automatic logic [15:0] rand_word(input int w, input logic mode);
        logic [15:0] d;
        d = 16'($urandom);
        if (w == 8) d[15:8] = '0;
        if ($urandom_range(0, 2) == 0) begin
            for (int i = 0; i < w/2; i++) d[w-1-i] = d[i] ^ mode;
        end
        return d;
    endfunction

    task automatic check_stats();
`ifdef SYMDET_STATS_EN
        check_eq("stat_words8", stat_words8, exp_words8);
        check_eq("stat_sym8", stat_sym8, exp_sym8);
        check_eq("stat_words16", stat_words16, exp_words16);
        check_eq("stat_sym16", stat_sym16, exp_sym16);
`else
        check_eq("stat_words8_off", stat_words8, 0);
        check_eq("stat_sym8_off", stat_sym8, 0);
        check_eq("stat_words16_off", stat_words16, 0);
        check_eq("stat_sym16_off", stat_sym16, 0);
`endif
    endtask

    initial begin
        logic [15:0] s;
        logic        saw_valid;
        logic        m;
        drive_in(8, 1'b0, 16'h0, 1'b0);
        drive_in(16, 1'b0, 16'h0, 1'b0);
        set_ready(8, 1'b1);
        set_ready(16, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state8", snap(8), 16'h0002);
        check_eq("reset_state16", snap(16), 16'h0002);
        check_eq("reset_stat_words8", stat_words8, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(8, 16'h00C3, 1'b0, 0);
        send(8, 16'h00D3, 1'b0, 0);
        send(8, 16'h0096, 1'b0, 0);
        send(8, 16'h00FF, 1'b0, 0);
        send(8, 16'h0096, 1'b1, 0);
        send(8, 16'h00FF, 1'b1, 0);
        send(8, 16'h00D3, 1'b0, 6);
        for (int n = 0; n < 20; n++) begin
            m = 1'($urandom);
            send(8, rand_word(8, m), m, $urandom_range(0, 3));
        end
        check_stats();

        // Reset while pass 2 of a word is in progress.
        send(8, 16'h0096, 1'b0, 0);
        drive_in(8, 1'b1, 16'h0081, 1'b0);
        @(posedge clk); #1;
        drive_in(8, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("reset_midscan_outputs", snap(8), 16'h0002);
        exp_words8 = 0; exp_sym8 = 0; exp_words16 = 0; exp_sym16 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            s = snap(8);
            if (s[0]) saw_valid = 1'b1;
        end
        check_eq("no_result_after_reset", {31'd0, saw_valid}, 0);
        send(8, 16'h00D3, 1'b0, 0);

        send(16, 16'hA5A5, 1'b0, 0);
        send(16, 16'h8001, 1'b1, 0);
        check_stats();
        for (int n = 0; n < 15; n++) begin
            m = 1'($urandom);
            send(16, rand_word(16, m), m, $urandom_range(0, 3));
        end
        check_stats();

        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        exp_words8 = 0; exp_sym8 = 0; exp_words16 = 0; exp_sym16 = 0;
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
